alu_cmd_issuer: RTL

Sequential front end for the combinational 8-bit `compare` ALU. Accepts operation commands over a valid/ready stream, drives the ALU's `a`/`b`/`ctrl` inputs from registers, and captures the ALU output `s`. Returns each result on a valid/ready response stream. Screens illegal control codes, supports result chaining, and keeps operation/illegal counters.

---
 rtl/alu_cmd_issuer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/alu_cmd_issuer.sv
// ============================================================================
// Module   : alu_cmd_issuer
// Purpose  : Valid/ready command front end for the 8-bit compare ALU, with
//            illegal-code screening, result chaining and op/illegal counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_issuer (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_ctrl,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic       cmd_chain,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_ctrl,
    input  logic [7:0] alu_s,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_illegal,
    output logic [7:0] op_count,
    output logic [7:0] illegal_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [3:0] c_CTRL_MIN = 4'd2;
    localparam logic [3:0] c_CTRL_MAX = 4'd11;
    localparam logic [7:0] c_CNT_MAX  = 8'hFF;

    state_t     r_state;
    state_t     w_next;
    logic       w_accept;
    logic       w_legal;
    logic [7:0] w_result;

    logic [7:0] r_alu_a;
    logic [7:0] r_alu_b;
    logic [3:0] r_alu_ctrl;
    logic       r_illegal;
    logic [7:0] r_last_result;
    logic       r_rsp_valid;
    logic [7:0] r_rsp_data;
    logic       r_rsp_illegal;
    logic [7:0] r_op_count;
    logic [7:0] r_illegal_count;

    assign w_legal  = (cmd_ctrl >= c_CTRL_MIN) && (cmd_ctrl <= c_CTRL_MAX);
    assign w_accept = cmd_valid && cmd_ready;
    // Illegal commands still run through the ALU (ctrl 0), but the result is forced to zero.
    assign w_result = r_illegal ? 8'h00 : alu_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_next = ISSUE;
                end
            end
            ISSUE: begin
                w_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_a         <= 8'h00;
            r_alu_b         <= 8'h00;
            r_alu_ctrl      <= 4'h0;
            r_illegal       <= 1'b0;
            r_last_result   <= 8'h00;
            r_rsp_valid     <= 1'b0;
            r_rsp_data      <= 8'h00;
            r_rsp_illegal   <= 1'b0;
            r_op_count      <= 8'h00;
            r_illegal_count <= 8'h00;
        end else begin
            if (w_accept) begin
                r_alu_a    <= cmd_chain ? r_last_result : cmd_a;
                r_alu_b    <= cmd_b;
                r_alu_ctrl <= w_legal ? cmd_ctrl : 4'h0;
                r_illegal  <= ~w_legal;
            end
            if (r_state == ISSUE) begin
                r_rsp_data    <= w_result;
                r_rsp_illegal <= r_illegal;
                r_last_result <= w_result;
                r_rsp_valid   <= 1'b1;
                r_op_count    <= r_op_count + 8'd1;
                if (r_illegal && (r_illegal_count != c_CNT_MAX)) begin
                    r_illegal_count <= r_illegal_count + 8'd1;
                end
            end
            if ((r_state == RESP) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign alu_a         = r_alu_a;
    assign alu_b         = r_alu_b;
    assign alu_ctrl      = r_alu_ctrl;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_data      = r_rsp_data;
    assign rsp_illegal   = r_rsp_illegal;
    assign op_count      = r_op_count;
    assign illegal_count = r_illegal_count;

endmodule

`default_nettype wire
